// File: rtl/demux_n.sv
// demux_n: one-to-N valid/ready demultiplexer with a one-entry register per lane.
// Define DEMUX_N_AUTO_SCAN_EN to steer beats round-robin from an internal scan pointer instead of select.
module demux_n #(
    parameter int N = 9,
    parameter int M = 4,
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    input  logic [M-1:0]   select,
    output logic           in_ready,
    output logic [N-1:0]   out_valid,
    output logic [N*W-1:0] out_data,
    input  logic [N-1:0]   out_ready,
    output logic [M-1:0]   cur_sel,
    output logic           sel_err
);

    // Handshake: a beat moves on a rising edge only when its valid and ready are both high;
    // valid never depends on ready, and a held beat stays unchanged until it is taken.

    logic [W-1:0] data_q [N];
    logic [N-1:0] valid_q;
    logic [N-1:0] hit;
    logic         accept;

`ifdef DEMUX_N_AUTO_SCAN_EN
    logic [M-1:0] scan_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ptr <= '0;
        end else if (accept) begin
            scan_ptr <= (scan_ptr == M'(N - 1)) ? '0 : scan_ptr + 1'b1;
        end
    end

    assign cur_sel = scan_ptr;
`else
    assign cur_sel = (N == 1) ? '0 : select;
`endif

    // An index >= N matches no lane, which leaves in_ready high and flags sel_err.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = (cur_sel == M'(i));
        end
    end

    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (hit[i]) begin
                in_ready = !valid_q[i] || out_ready[i];
            end
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept && hit[i]) begin
                    valid_q[i] <= 1'b1;
                    data_q[i]  <= in_data;
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && (hit == '0)) begin
            sel_err <= 1'b1;
        end
    end

    assign out_valid = valid_q;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            out_data[i*W +: W] = data_q[i];
        end
    end

endmodule

// File: tb/tb_demux_n.sv
// tb_demux_n: randomized scoreboard bench for demux_n; each lane's pending beats are kept in a queue.
module tb_demux_n;

    localparam int N = 9;
    localparam int M = 4;
    localparam int W = 1;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [M-1:0]   select;
    logic           in_ready;
    logic [N-1:0]   out_valid;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_ready;
    logic [M-1:0]   cur_sel;
    logic           sel_err;

    demux_n #(.N(N), .M(M), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .select    (select),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .sel_err   (sel_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    int         total = 0;
    int         bad = 0;
    logic [W-1:0] exp_q [N][$];
    logic       m_err;
    int         m_ptr;
    logic       mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int target_lane(input logic [M-1:0] s);
`ifdef DEMUX_N_AUTO_SCAN_EN
        return m_ptr;
`else
        return (N == 1) ? 0 : int'(s);
`endif
    endfunction

    function automatic logic lane_full(input int lane);
        return exp_q[lane].size() != 0;
    endfunction

    // driver: one beat opportunity per clock
    task automatic cycle(input logic v, input logic [M-1:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] ordy);
        int   lane;
        logic er;
        @(negedge clk);
        in_valid  = v;
        select    = s;
        in_data   = d;
        out_ready = ordy;
        #1;
        lane = target_lane(s);
        er   = (lane >= N) ? 1'b1 : (!lane_full(lane) || ordy[lane]);
        check("in_ready", 64'(in_ready), 64'(er));
        check("cur_sel", 64'(cur_sel), 64'(lane));
        #2;
        if (v && er) begin
            if (lane < N) exp_q[lane].push_back(d);
            else m_err = 1'b1;
            m_ptr = (m_ptr + 1) % N;
        end
    endtask

    // monitor: compares what every lane presents against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int i = 0; i < N; i++) begin
                    check($sformatf("lane%0d_valid", i), 64'(out_valid[i]), 64'(lane_full(i)));
                    if (lane_full(i)) begin
                        check($sformatf("lane%0d_data", i), 64'(out_data[i*W +: W]), 64'(exp_q[i][0]));
                        if (out_valid[i] && out_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
                check("sel_err", 64'(sel_err), 64'(m_err));
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        m_err = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        select    = '0;
        out_ready = '0;
        mon_en    = 1'b0;
        clear_model();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_sel_err", 64'(sel_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

`ifndef DEMUX_N_AUTO_SCAN_EN
        // single beat into lane 5
        cycle(1'b1, M'(5), W'(1), '0);
        #3;
        check("first_out_valid", 64'(out_valid), 64'(9'b000100000));
        check("first_lane5_data", 64'(out_data[5*W +: W]), 64'(1));
        // stalled lane refuses, then drain-and-reload keeps valid high
        cycle(1'b1, M'(5), W'(0), '0);
        cycle(1'b1, M'(5), W'(0), N'(9'b000100000));
        #3;
        check("reload_valid5", 64'(out_valid[5]), 64'(1));
        check("reload_data5", 64'(out_data[5*W +: W]), 64'(0));
        // out-of-range index is swallowed and flagged
        cycle(1'b1, M'(12), W'(1), '0);
        #3;
        check("oor_out_valid", 64'(out_valid), 64'(9'b000100000));
        check("oor_sel_err", 64'(sel_err), 64'(1));
        cycle(1'b1, M'(0), W'(1), '0);
        cycle(1'b1, M'(3), W'(1), '0);
        cycle(1'b1, M'(8), W'(0), '0);
`else
        // round-robin fill with select toggling
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, M'(k % 2 ? 5 : 12), W'(k), '1);
        end
        check("scan_wrap_ptr", 64'(cur_sel), 64'(1));
        cycle(1'b1, M'(0), W'(1), '0);
        cycle(1'b1, M'(0), W'(1), '0);
        cycle(1'b1, M'(0), W'(1), '0);
`endif

        // asynchronous reset in the middle of a low clock phase
        @(negedge clk);
        mon_en   = 1'b0;
        in_valid = 1'b1;
        select   = M'(2);
        out_ready = '0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_sel_err", 64'(sel_err), 64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
        check("async_rst_cur_sel", 64'(cur_sel), 64'(target_lane(M'(2)) == 2 ? 2 : 0));
        clear_model();
        @(posedge clk);
        #1;
        check("no_accept_in_rst", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;

        // randomized traffic with bursts of back-pressure
        for (int k = 0; k < 3000; k++) begin
            logic [M-1:0] s;
            logic [N-1:0] ordy;
            s = ($urandom_range(0, 15) == 0) ? M'($urandom_range(N, 15)) : M'($urandom_range(0, N - 1));
            ordy = N'($urandom);
            if ((k / 200) % 2 == 1) ordy = ordy & N'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), s, W'($urandom), ordy);
        end

        cycle(1'b0, '0, '0, '1);
        cycle(1'b0, '0, '0, '1);
        #3;
        check("final_drained", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
